microinstruction_pipe: RTL
==========================

MICROINSTRUCTION_PIPE -- requirements
Module: microinstruction_pipe

Interface
REQ-001 Parameter: DEPTH, 3, number of pipeline stages (1..16).
REQ-002 Parameter: CW, 6, control-word width (C field).
REQ-003 Parameter: TW, 7, tag/target-word width (T field).
REQ-004 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-005 Port: reset_n  input  1  reset; synchronous and active-low.
REQ-006 Port: flush  input  1  kill all in-flight microinstructions.
REQ-007 Port: in_valid  input  1  upstream microinstruction present.
REQ-008 Port: in_c  input  CW  upstream control word.
REQ-009 Port: in_t  input  TW  upstream tag word.
REQ-010 Port: in_ready  output  1  pipe accepts in_c/in_t this cycle.
REQ-011 Port: out_valid  output  1  last stage holds a valid microinstruction.
REQ-012 Port: out_c  output  CW  last-stage control word.
REQ-013 Port: out_t  output  TW  last-stage tag word.
REQ-014 Port: out_ready  input  1  downstream consumes out_c/out_t this cycle.
REQ-015 Port: stage_valid  output  DEPTH  per-stage valid bits, bit 0 = first stage.
REQ-016 Port: occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-017 Transfers SHALL occur on a rising edge where valid and ready are both 1, at input and output independently.
REQ-018 Stage i SHALL advance when empty or when stage i+1 advances; last stage advances when empty or out_ready=1.
REQ-019 in_ready SHALL equal the advance condition of stage 0 (combinational, no dependence on in_valid).
REQ-020 Bubbles SHALL collapse: a stalled output SHALL NOT block earlier stages while any downstream stage is empty.
REQ-021 Latency SHALL be DEPTH cycles from input transfer to out_valid=1 when out_ready stays 1; throughput one per cycle.
REQ-022 A stage that advances with no valid predecessor SHALL become invalid; its C/T registers SHALL hold their previous value.
REQ-023 out_c/out_t SHALL be forced to all-zero whenever out_valid=0 (NOP presented downstream).
REQ-024 C and T SHALL travel together unmodified; no field SHALL be reordered or truncated.
REQ-025 flush=1 SHALL clear every stage_valid bit at the next edge; in_valid on the flush cycle is discarded.
REQ-026 During flush=1, in_ready SHALL read 0 and an out transfer in that cycle SHALL still count as consumed.
REQ-027 occupancy SHALL equal popcount(stage_valid), registered with the stages, max DEPTH, never wrapping.
REQ-028 Simultaneous input and output transfer with full pipe SHALL keep occupancy at DEPTH.
REQ-029 DEPTH=1 SHALL behave as a single registered stage with the same handshake rules.

Reset
REQ-030 reset_n=0 at a rising edge SHALL clear all stage_valid, all C/T registers and occupancy to 0.
REQ-031 reset_n SHALL take priority over flush and all transfers; an asserted mid-stream reset SHALL drop all in-flight words.
REQ-032 In the first cycle after reset_n returns to 1, in_ready SHALL be 1 and out_valid 0.

Structure
REQ-033 Package microinstruction_pkg SHALL hold CW_DEFAULT=6, TW_DEFAULT=7 and the packed {C,T} microinstruction typedef.
REQ-034 One sub-module microinstruction_stage SHALL implement a single valid+C+T register with advance/flush inputs, instantiated DEPTH times by generate.

Verification
REQ-035 DEPTH=3, out_ready=1, inputs C=0x2A/T=0x55 then C=0x15/T=0x2A -> out in cycles 3 and 4, occupancy 1,2,2,1,0.
REQ-036 Fill 3 words with out_ready=0 -> stage_valid=3'b111, occupancy=3, in_ready=0; raise out_ready -> one word per cycle in order.
REQ-037 Single word, out_ready=0 for 5 cycles -> word reaches last stage in 3 cycles, held stable, out_c/out_t unchanged until transfer.
REQ-038 Full pipe, flush=1 with in_valid=1 -> next cycle stage_valid=0, occupancy=0, out_c=out_t=0, flushed input never emerges.
REQ-039 reset_n=0 for one cycle mid-stream with 2 words in flight -> all outputs 0 next cycle, in_ready=1, no old word emerges.
REQ-040 DEPTH=1, CW=8, TW=12, random valid/ready for 1000 cycles -> scoreboard: order preserved, no loss, no duplication.

Source files
------------

// File: rtl/microinstruction_pkg.sv
// Purpose: shared widths and the packed {C,T} microinstruction word for the pipe.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package microinstruction_pkg;

    localparam int CW_DEFAULT = 6;
    localparam int TW_DEFAULT = 7;

    // C sits in the upper bits and T in the lower bits. The pipe uses the same
    // {c, t} ordering when it builds a word from any other CW/TW.
    typedef struct packed {
        logic [CW_DEFAULT-1:0] c;
        logic [TW_DEFAULT-1:0] t;
    } uinstr_t;

    localparam int UINSTR_W = $bits(uinstr_t);

endpackage

// File: rtl/microinstruction_stage.sv
// Purpose: one pipe slot, holding a valid bit and a {C,T} payload.
// Latency: 1 cycle. The slot loads on the edge where advance=1.
// Backpressure: holds while advance=0. flush clears only the valid bit. reset_n clears everything.
// Ports: clock/reset_n (sync, active-low); flush, advance and in_vld/in_dat from the
//        predecessor; vld/dat are registered; vld_nxt is next-cycle valid for occupancy.
module microinstruction_stage
    import microinstruction_pkg::*;
#(
    parameter int W = UINSTR_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         advance,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         vld,
    output logic         vld_nxt,
    output logic [W-1:0] dat
);

    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (advance) begin
            vld_d = in_vld;
            // When the slot advances into a bubble, the payload keeps its old
            // value so that the data path does not toggle on empty slots.
            if (in_vld) begin
                dat_d = in_dat;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld     = vld_q;
    assign vld_nxt = reset_n ? vld_d : 1'b0;
    assign dat     = dat_q;

endmodule

// File: rtl/microinstruction_pipe.sv
// Purpose: a DEPTH-stage valid/ready pipe for {C,T} microinstructions in which bubbles collapse.
// Latency: DEPTH cycles from the input transfer to out_valid. Throughput is one word per cycle.
// Backpressure: a stage stalls only if it and every later stage are full and out_ready=0.
// Ports: clock/reset_n (sync, active-low); flush kills all in-flight words;
//        in_* and out_* are valid/ready handshakes. out_c/out_t are zero when out_valid=0.
//        stage_valid (bit 0 = first stage) and occupancy are registered status outputs.
module microinstruction_pipe
    import microinstruction_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int CW    = CW_DEFAULT,
    parameter int TW    = TW_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [CW-1:0]              in_c,
    input  logic [TW-1:0]              in_t,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [CW-1:0]              out_c,
    output logic [TW-1:0]              out_t,
    input  logic                       out_ready,
    output logic [DEPTH-1:0]           stage_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int DW = CW + TW;
    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_nxt;
    logic [DEPTH-1:0] adv;
    logic [DW-1:0]    dat [DEPTH];
    logic [OW-1:0]    occ_q, occ_d;

    // The advance chain is built from the output backwards. A stage moves if it
    // is empty or if its successor moves. An empty slot anywhere downstream
    // therefore lets every earlier stage move up, which collapses the bubble.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = !vld[DEPTH-1] || out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = !vld[i] || adv[i+1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic          prev_vld;
        logic [DW-1:0] prev_dat;

        if (g == 0) begin : g_head
            assign prev_vld = in_valid;
            assign prev_dat = {in_c, in_t};
        end else begin : g_body
            assign prev_vld = vld[g-1];
            assign prev_dat = dat[g-1];
        end

        microinstruction_stage #(
            .W (DW)
        ) u_stage (
            .clock   (clock),
            .reset_n (reset_n),
            .flush   (flush),
            .advance (adv[g]),
            .in_vld  (prev_vld),
            .in_dat  (prev_dat),
            .vld     (vld[g]),
            .vld_nxt (vld_nxt[g]),
            .dat     (dat[g])
        );
    end

    // Occupancy is registered from the next-state valid bits. It therefore
    // updates on the same edge as stage_valid and cannot exceed DEPTH.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OW'(vld_nxt[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    always_comb begin
        out_c = '0;
        out_t = '0;
        if (vld[DEPTH-1]) begin
            out_c = dat[DEPTH-1][DW-1:TW];
            out_t = dat[DEPTH-1][TW-1:0];
        end
    end

    assign in_ready    = adv[0] && !flush;
    assign out_valid   = vld[DEPTH-1];
    assign stage_valid = vld;
    assign occupancy   = occ_q;

endmodule
